// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one memory port between two masters: m0 (instruction fetch) and
// m1 (load/store). Each master fires a one-cycle read and/or write strobe.
// The arbiter latches that request into a per-port slot, issues it to memory
// with a stable address, and waits for completion. It then returns read data
// and a one-cycle done pulse to the master that owns the transaction.
//
// Parameters
//   PRIO    : 0 = round-robin between m0/m1, 1 = fixed priority (m1 wins)
//   TIMEOUT : WAIT cycles without mem_done before an error completion (2..255)
//
// Ports
//   clk, rst_n                 : clock, synchronous active-low reset
//   mX_addr/wdata/wmask        : request fields, sampled with the strobe
//   mX_wstrobe/rstrobe         : one-cycle write/read request pulses
//   mX_rdata                   : registered read data, held until next completion
//   mX_done/err                : completion pulse, err qualifies it
//   mX_busy                    : request pending or in flight
//   mem_addr/wdata/wmask       : request to memory, held for the whole transaction
//   mem_wstrobe/rstrobe        : one-cycle strobes to memory
//   mem_rdata/done/active      : memory response; active = address is mapped
module mem_arbiter #(
  parameter int PRIO    = 0,
  parameter int TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  input  logic        m0_wstrobe,
  input  logic        m0_rstrobe,
  output logic [31:0] m0_rdata,
  output logic        m0_done,
  output logic        m0_err,
  output logic        m0_busy,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  input  logic        m1_wstrobe,
  input  logic        m1_rstrobe,
  output logic [31:0] m1_rdata,
  output logic        m1_done,
  output logic        m1_err,
  output logic        m1_busy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        mem_wstrobe,
  output logic        mem_rstrobe,
  input  logic [31:0] mem_rdata,
  input  logic        mem_done,
  input  logic        mem_active
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, COMPLETE} state_t;

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             rr_q, rr_d;
  logic             err_q, err_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [1:0]       pend_q, pend_d;
  logic [1:0]       rd_q, rd_d, wr_q, wr_d;
  logic [1:0][31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0][3:0]  wmask_q, wmask_d;
  logic [31:0]      maddr_q, maddr_d, mwdata_q, mwdata_d;
  logic [3:0]       mwmask_q, mwmask_d;

  logic [1:0][31:0] in_addr, in_wdata;
  logic [1:0][3:0]  in_wmask;
  logic [1:0]       in_rd, in_wr, done, accept, req;
  logic             other, grant, start;

  assign in_addr  = {m1_addr, m0_addr};
  assign in_wdata = {m1_wdata, m0_wdata};
  assign in_wmask = {m1_wmask, m0_wmask};
  assign in_rd    = {m1_rstrobe, m0_rstrobe};
  assign in_wr    = {m1_wstrobe, m0_wstrobe};
  assign other    = ~owner_q;

  assign done[0] = (state_q == COMPLETE) && !owner_q;
  assign done[1] = (state_q == COMPLETE) && owner_q;

  // A port accepts a new strobe when idle, or in the very cycle its done
  // pulses, because its slot is freed at the end of that cycle.
  assign accept = (in_rd | in_wr) & (~pend_q | done);
  // Requests being accepted this cycle count as pending for arbitration.
  // This lets a strobe in cycle T reach ISSUE in cycle T+1.
  assign req    = pend_q | accept;

  // Slot capture: latch the request fields and clear the slot on completion.
  always_comb begin
    pend_d  = pend_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    for (int p = 0; p < 2; p++) begin
      if (done[p]) pend_d[p] = 1'b0;
      if (accept[p]) begin
        pend_d[p]  = 1'b1;
        addr_d[p]  = in_addr[p];
        wdata_d[p] = in_wdata[p];
        wmask_d[p] = in_wmask[p];
        rd_d[p]    = in_rd[p];
        wr_d[p]    = in_wr[p];
      end
    end
  end

  // Transaction sequencer and arbitration. The memory request registers are
  // loaded from the slot's next-state values so that a request latched in
  // the same edge is already visible in ISSUE.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    mwmask_d = mwmask_q;
    grant    = 1'b0;
    start    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          start = 1'b1;
          if (&req) grant = (PRIO == 1) ? 1'b1 : rr_q;
          else      grant = req[1];
        end
      end
      ISSUE: begin
        if (!mem_active) begin
          state_d          = COMPLETE;
          err_d            = 1'b1;
          rdata_d[owner_q] = '0;
        end else begin
          state_d = WAIT;
          cnt_d   = 8'd1;
        end
      end
      WAIT: begin
        if (mem_done) begin
          state_d          = COMPLETE;
          err_d            = 1'b0;
          rdata_d[owner_q] = mem_rdata;
          cnt_d            = '0;
        end else if (cnt_q == TimeoutCnt) begin
          state_d          = COMPLETE;
          err_d            = 1'b1;
          rdata_d[owner_q] = '0;
          cnt_d            = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      COMPLETE: begin
        // The pointer names the port preferred next: the one not just served.
        rr_d = other;
        if (req[other]) begin
          start = 1'b1;
          grant = other;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (start) begin
      state_d  = ISSUE;
      owner_d  = grant;
      err_d    = 1'b0;
      maddr_d  = addr_d[grant];
      mwdata_d = wdata_d[grant];
      mwmask_d = wmask_d[grant];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      rr_q     <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      pend_q   <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      rdata_q  <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      mwmask_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      rdata_q  <= rdata_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      mwmask_q <= mwmask_d;
    end
  end

  assign mem_addr    = maddr_q;
  assign mem_wdata   = mwdata_q;
  assign mem_wmask   = mwmask_q;
  assign mem_wstrobe = (state_q == ISSUE) && wr_q[owner_q];
  assign mem_rstrobe = (state_q == ISSUE) && rd_q[owner_q];

  assign m0_rdata = rdata_q[0];
  assign m0_done  = done[0];
  assign m0_err   = done[0] && err_q;
  assign m0_busy  = pend_q[0];
  assign m1_rdata = rdata_q[1];
  assign m1_done  = done[1];
  assign m1_err   = done[1] && err_q;
  assign m1_busy  = pend_q[1];

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master, single-slave arbiter in front of a `memory` instance. Shares the one memory port between the instruction-fetch master (m0) and the load/store master (m1).
- Latches each master's strobe-style request and issues it to memory with the address held stable. Waits for completion, then returns read data and a done pulse to the owning master.
- Provides round-robin or fixed priority, error on unmapped address (`mem_active` low), and a completion timeout.

Parameters:
- PRIO, 0: 0 = round-robin between m0/m1; 1 = fixed priority, m1 wins.
- TIMEOUT, 8: max WAIT cycles without `mem_done` before error completion; legal range 2..255.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous reset, active-low
- m0_addr  in  32  m0 byte address, sampled when m0 strobes
- m0_wdata  in  32  m0 write data, sampled with strobe
- m0_wmask  in  4  m0 byte enables, sampled with strobe
- m0_wstrobe  in  1  m0 write request, 1-cycle pulse
- m0_rstrobe  in  1  m0 read request, 1-cycle pulse
- m0_rdata  out  32  m0 read data, registered, held until next m0 completion
- m0_done  out  1  m0 completion, 1-cycle pulse
- m0_err  out  1  qualifies m0_done: timeout or unmapped
- m0_busy  out  1  m0 request pending or in flight
- m1_* (addr, wdata, wmask, wstrobe, rstrobe, rdata, done, err, busy): identical to m0_*
- mem_addr  out  32  to memory
- mem_wdata  out  32  to memory
- mem_wmask  out  4  to memory
- mem_wstrobe  out  1  to memory
- mem_rstrobe  out  1  to memory
- mem_rdata  in  32  from memory, valid the cycle after strobe
- mem_done  in  1  from memory
- mem_active  in  1  from memory; address decodes to memory

Behaviour:
- Reset: state IDLE, pending/busy = 0, all strobes/done/err = 0, rdata = 0, mem_addr/wdata/wmask = 0, RR pointer = m0, timeout counter = 0.
- Capture:
  - Either strobe high while that port is not busy latches addr, wdata, wmask and the rd/wr flags into the port slot; busy rises next cycle.
  - A strobe while busy is ignored (protocol violation, no effect).
  - A strobe in the cycle the port's done pulses is accepted.
- States:
  - IDLE: if any slot pending, select grant and go to ISSUE.
  - ISSUE, one cycle: `mem_addr`/`wdata`/`wmask` come from the granted slot; `mem_wstrobe`/`mem_rstrobe` equal the slot's flags. Both flags set forwards both strobes; read returns pre-write data.
    - `mem_active` = 0 here → COMPLETE with err = 1.
    - Otherwise → WAIT, counter = 1.
  - WAIT: `mem_addr` held, strobes 0.
    - `mem_done` = 1 → capture `mem_rdata` into the owner's rdata; COMPLETE, err = 0.
    - Else counter increments; counter == TIMEOUT → COMPLETE, err = 1.
  - COMPLETE, one cycle:
    - Owner's done = 1 and err as set; owner's busy clears at end of cycle.
    - Error completion forces the owner's rdata to 0.
    - Other slot pending → ISSUE (re-arbitrate), else IDLE.
- Grant:
  - Only one pending → it wins.
  - Both pending, PRIO = 0 → the port not served last; RR pointer updates on each COMPLETE.
  - Both pending, PRIO = 1 → m1.
- Latency: strobe in cycle T → ISSUE T+1 → WAIT T+2 → done pulse T+3 (nominal). Throughput: one transaction per 3 cycles when back-to-back.
- Writes: complete on `mem_done` like reads; the owner's rdata is updated with `mem_rdata` (don't-care to masters).
- Reset mid-operation: drops all in-flight and pending requests, no done pulse issued, outputs to reset values next cycle.

Test Plan:
- m0 read addr 0x10, mem word4 = 0xDEADBEEF → mem_rstrobe at T+1 with addr 0x10; m0_done at T+3, m0_rdata = 0xDEADBEEF, err = 0.
- m0 read 0x20 and m1 write 0x40/0x12345678/mask 4'b0011 in the same cycle, PRIO = 0, RR at m0 → m0 issued first, m1 issued in the cycle after m0_done; a later read of 0x40 shows only the low 16 bits written.
- PRIO = 1, both strobe together 4 times back-to-back → m1 always granted first; with PRIO = 0, grants alternate m0, m1, m0, m1.
- m1 read 0x8000 with `mem_active` = 0 → m1_done at T+2 with m1_err = 1, m1_rdata = 0, no WAIT entered.
- `mem_done` held 0, TIMEOUT = 8 → m0_done with err = 1 exactly 8 WAIT cycles after ISSUE; arbiter returns to IDLE.
- rst_n low during WAIT with m1 pending → no done pulses, busy = 0, mem strobes 0 next cycle; a fresh m0 read after release completes normally.
